// File: rtl/dequant_4x4_if.sv
// Block-level bus of dequant_4x4: QP and zig-zag level stream in, parallel raster-order coefficient block out.
// The master side (upstream/downstream stimulus) drives levels and out_ready; the slave side is the dequantizer.
interface dequant_4x4_if #(
    parameter int BIT_LENGTH = 15,
    parameter int COEF_W     = 12
);
    logic [5:0]                    qp;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [COEF_W-1:0]      in_level;
    logic                          out_valid;
    logic                          out_ready;
    logic [15:0][BIT_LENGTH:0]     out_coefs;

    modport master (
        output qp, in_valid, in_level, out_ready,
        input  in_ready, out_valid, out_coefs
    );

    modport slave (
        input  qp, in_valid, in_level, out_ready,
        output in_ready, out_valid, out_coefs
    );
endinterface

// File: rtl/dequant_4x4.sv
// Purpose: H.264 flat-matrix 4x4 dequantizer, zig-zag level stream in, raster coefficient block out.
// Latency: out_valid one cycle after the 16th level; 17 cycles per block with out_ready high.
// Backpressure: block held (in_ready low) until out_ready && enable; DEQUANT_SAT_EN selects saturation over wrap.
module dequant_4x4 #(
    parameter int BIT_LENGTH = 15,
    parameter int COEF_W     = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    dequant_4x4_if.slave  bus
);
    localparam int OW = BIT_LENGTH + 1;

    typedef enum logic {FILL, HOLD} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [5:0]            qp_q, qp_d;
    logic [15:0][OW-1:0]   coefs_q, coefs_d;

    logic [5:0]            qp_clamp, qp_eff;
    logic [3:0]            qp_div;
    logic [2:0]            qp_mod;
    logic [3:0]            raster;
    logic [4:0]            v;
    logic signed [OW-1:0]  d;

    function automatic logic [3:0] zz2raster(input logic [3:0] scan);
        case (scan)
            4'd0:    return 4'd0;
            4'd1:    return 4'd1;
            4'd2:    return 4'd4;
            4'd3:    return 4'd8;
            4'd4:    return 4'd5;
            4'd5:    return 4'd2;
            4'd6:    return 4'd3;
            4'd7:    return 4'd6;
            4'd8:    return 4'd9;
            4'd9:    return 4'd12;
            4'd10:   return 4'd13;
            4'd11:   return 4'd10;
            4'd12:   return 4'd7;
            4'd13:   return 4'd11;
            4'd14:   return 4'd14;
            default: return 4'd15;
        endcase
    endfunction

    // The first level of a block must use the QP arriving with it, not the stale latch.
    assign qp_clamp = (bus.qp > 6'd51) ? 6'd51 : bus.qp;
    assign qp_eff   = (cnt_q == 4'd0) ? qp_clamp : qp_q;
    assign raster   = zz2raster(cnt_q);

    always_comb begin
        qp_div = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            if (qp_eff >= 6'(6 * k)) qp_div = 4'(k);
        end
        qp_mod = 3'(qp_eff - 6'(6 * qp_div));
    end

    always_comb begin
        v = 5'd0;
        if (!raster[2] && !raster[0]) begin
            case (qp_mod)
                3'd0: v = 5'd10;  3'd1: v = 5'd11;  3'd2: v = 5'd13;
                3'd3: v = 5'd14;  3'd4: v = 5'd16;  default: v = 5'd18;
            endcase
        end else if (raster[2] && raster[0]) begin
            case (qp_mod)
                3'd0: v = 5'd16;  3'd1: v = 5'd18;  3'd2: v = 5'd20;
                3'd3: v = 5'd23;  3'd4: v = 5'd25;  default: v = 5'd29;
            endcase
        end else begin
            case (qp_mod)
                3'd0: v = 5'd13;  3'd1: v = 5'd14;  3'd2: v = 5'd16;
                3'd3: v = 5'd18;  3'd4: v = 5'd20;  default: v = 5'd23;
            endcase
        end
    end

`ifdef DEQUANT_SAT_EN
    localparam int PW = COEF_W + 13;
    localparam logic signed [PW-1:0] SAT_MAX = PW'((64'sd1 <<< BIT_LENGTH) - 64'sd1);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-(64'sd1 <<< BIT_LENGTH));

    logic signed [PW-1:0] prod_full;

    always_comb begin
        prod_full = (PW'(bus.in_level) * PW'($signed({1'b0, v}))) <<< qp_div;
        if (prod_full > SAT_MAX)      d = OW'(SAT_MAX);
        else if (prod_full < SAT_MIN) d = OW'(SAT_MIN);
        else                          d = prod_full[OW-1:0];
    end
`else
    // Wrapping result only needs the low OW bits, which modular arithmetic gives exactly.
    always_comb begin
        d = (OW'(bus.in_level) * OW'($signed({1'b0, v}))) <<< qp_div;
    end
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        qp_d          = qp_q;
        coefs_d       = coefs_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            FILL: begin
                bus.in_ready = enable;
                if (enable && bus.in_valid) begin
                    coefs_d[raster] = d;
                    cnt_d           = cnt_q + 4'd1;
                    if (cnt_q == 4'd0)  qp_d    = qp_clamp;
                    if (cnt_q == 4'd15) state_d = HOLD;
                end
            end
            default: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready && enable) begin
                    state_d = FILL;
                    cnt_d   = 4'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            cnt_q   <= 4'd0;
            qp_q    <= 6'd0;
            coefs_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qp_q    <= qp_d;
            coefs_q <= coefs_d;
        end
    end

    assign bus.out_coefs = coefs_q;
endmodule

// File: tb/tb_dequant_4x4.sv
// Directed bench for dequant_4x4: hand-computed coefficients, handshake timing, enable freeze and async reset.
module tb_dequant_4x4;
    logic clk, rst_n, enable;
    int   checks = 0;
    int   errors = 0;

    logic signed [11:0] lv [16];
    logic [5:0]         qp0, qp_rest;
    int                 zz [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

    dequant_4x4_if #(.BIT_LENGTH(15), .COEF_W(12)) bus ();

    dequant_4x4 #(.BIT_LENGTH(15), .COEF_W(12)) dut (
        .clk    (clk),
        .reset  (rst_n),
        .enable (enable),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] coef(input int i);
        return 32'($signed(bus.out_coefs[i]));
    endfunction

    function automatic int nonzero();
        int n = 0;
        for (int i = 0; i < 16; i++) if (bus.out_coefs[i] != '0) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int from, input int upto);
        for (int k = from; k <= upto; k++) begin
            bus.in_valid = 1'b1;
            bus.in_level = lv[k];
            bus.qp       = (k == 0) ? qp0 : qp_rest;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic fill_lv(input int first, input int rest);
        for (int k = 0; k < 16; k++) lv[k] = 12'((k == 0) ? first : rest);
    endtask

    task automatic release_blk();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("release_vld", 32'(bus.out_valid), 0);
        check("release_rdy", 32'(bus.in_ready), 1);
    endtask

    initial begin
        int v;
        enable        = 1'b1;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_level  = '0;
        bus.qp        = '0;
        bus.out_ready = 1'b0;
        qp0           = 6'd0;
        qp_rest       = 6'd0;
        #12 rst_n = 1'b1;
        tick();

        check("rst_vld", 32'(bus.out_valid), 0);
        check("rst_rdy", 32'(bus.in_ready), 1);
        check("rst_nonzero", nonzero(), 0);

        // qp 0, all ones
        fill_lv(1, 1);
        send(0, 14);
        check("ones_pre16_vld", 32'(bus.out_valid), 0);
        send(15, 15);
        check("ones_vld", 32'(bus.out_valid), 1);
        check("ones_rdy", 32'(bus.in_ready), 0);
        check("ones_c0", coef(0), 10);
        check("ones_c5", coef(5), 16);
        check("ones_c1", coef(1), 13);
        check("ones_c15", coef(15), 16);
        check("ones_c2", coef(2), 10);
        check("ones_c4", coef(4), 13);
        release_blk();

        // qp 28, single DC level
        fill_lv(1, 0);
        qp0 = 6'd28;
        send(0, 15);
        check("qp28_c0", coef(0), 256);
        check("qp28_nonzero", nonzero(), 1);
        release_blk();

        qp0 = 6'd51;
        send(0, 15);
        check("qp51_c0", coef(0), 3584);
        release_blk();
        qp0 = 6'd60;
        send(0, 15);
        check("qp60_clamp_c0", coef(0), 3584);
        release_blk();

        // Extreme levels at qp 51
        fill_lv(2047, 0);
        qp0 = 6'd51;
        send(0, 15);
`ifdef DEQUANT_SAT_EN
        check("max_c0", coef(0), 32767);
`else
        check("max_c0", coef(0), -3584);
`endif
        release_blk();
        fill_lv(-2048, 0);
        send(0, 15);
`ifdef DEQUANT_SAT_EN
        check("min_c0", coef(0), -32768);
`else
        check("min_c0", coef(0), 0);
`endif
        release_blk();

        // Zig-zag map; QP changing after scan 0 must be ignored
        for (int k = 0; k < 16; k++) lv[k] = 12'(k + 1);
        qp0     = 6'd12;
        qp_rest = 6'd0;
        send(0, 15);
        for (int k = 0; k < 16; k++) begin
            int r, c;
            r = zz[k] / 4;
            c = zz[k] % 4;
            if (r % 2 == 0 && c % 2 == 0)      v = 10;
            else if (r % 2 == 1 && c % 2 == 1) v = 16;
            else                               v = 13;
            check($sformatf("zz_scan%0d", k), coef(zz[k]), (k + 1) * v * 4);
        end

        // Backpressure with upstream pushing
        bus.in_valid = 1'b1;
        bus.in_level = 12'sd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_vld", 32'(bus.out_valid), 1);
            check("bp_rdy", 32'(bus.in_ready), 0);
            check("bp_c4", coef(4), 156);
        end
        bus.in_valid = 1'b0;
        release_blk();

        // Enable low for 3 cycles after 7 levels
        for (int k = 0; k < 16; k++) lv[k] = 12'((k < 7) ? 1 : 2);
        qp0 = 6'd0;
        send(0, 6);
        enable       = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_level = 12'sd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en_rdy", 32'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        enable       = 1'b1;
        send(7, 14);
        check("en_pre_vld", 32'(bus.out_valid), 0);
        send(15, 15);
        check("en_vld", 32'(bus.out_valid), 1);
        check("en_c6", coef(6), 26);
        check("en_c5", coef(5), 16);
        enable        = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("en_hold_vld", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b0;
        enable        = 1'b1;
        release_blk();

        // Async reset mid-block
        fill_lv(1, 1);
        send(0, 6);
        rst_n = 1'b0;
        #2;
        check("arst_vld", 32'(bus.out_valid), 0);
        check("arst_nonzero", nonzero(), 0);
        rst_n = 1'b1;
        tick();
        send(0, 14);
        check("arst_pre16_vld", 32'(bus.out_valid), 0);
        send(15, 15);
        check("arst_vld16", 32'(bus.out_valid), 1);
        check("arst_c0", coef(0), 10);
        release_blk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
